// File: rtl/spi_responder.sv
// spi_responder: SPI mode-3 responder oversampled on clk_48, with a one-byte transmit buffer
module spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF
) (
    input  logic       clk_48,
    input  logic       rst,
    input  logic       spi_cs_n,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_empty,
    output logic       tx_underrun,
    output logic       frame_active,
    output logic       frame_start,
    output logic       frame_end
);
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    typedef enum logic [1:0] {WAIT_IDLE, IDLE, ACTIVE} state_t;

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] cs_q, mosi_q;
    logic [SYNC_STAGES:0]   clk_q;
    logic                   cs_s, mosi_s, running, sclk_fall, sclk_rise, byte_start, tx_full;
    logic [2:0]             bit_cnt;
    logic [7:0]             tx_buf, tx_sh, tx_next;
    logic [6:0]             rx_sh;

    assign cs_s         = cs_q[SYNC_STAGES-1];
    assign mosi_s       = mosi_q[SYNC_STAGES-1];
    assign frame_active = state == ACTIVE;
    assign spi_miso_oe  = frame_active;
    assign tx_empty     = !tx_full;

    // WAIT_IDLE holds until CS is seen high, so a frame in flight at reset is never joined
    always_comb begin
        state_nxt  = (state == WAIT_IDLE && !cs_s) ? WAIT_IDLE : (cs_s ? IDLE : ACTIVE);
        running    = state == ACTIVE && !cs_s;
        sclk_fall  = running && clk_q[SYNC_STAGES] && !clk_q[SYNC_STAGES-1];
        sclk_rise  = running && !clk_q[SYNC_STAGES] && clk_q[SYNC_STAGES-1];
        byte_start = sclk_fall && bit_cnt == 3'd0;
        tx_next    = tx_full ? tx_buf : IDLE_BYTE;
    end

    always_ff @(posedge clk_48 or posedge rst) begin
        if (rst) begin
            state       <= WAIT_IDLE;
            cs_q        <= '0;
            clk_q       <= '1;
            mosi_q      <= '0;
            bit_cnt     <= 3'd0;
            tx_buf      <= 8'h00;
            tx_full     <= 1'b0;
            tx_sh       <= 8'h00;
            rx_sh       <= 7'h00;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            spi_miso    <= 1'b1;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cs_q        <= {cs_q[SYNC_STAGES-2:0], spi_cs_n};
            clk_q       <= {clk_q[SYNC_STAGES-1:0], spi_clk};
            mosi_q      <= {mosi_q[SYNC_STAGES-2:0], spi_mosi};
            frame_start <= state == IDLE && !cs_s;
            frame_end   <= state == ACTIVE && cs_s;
            rx_valid    <= sclk_rise && bit_cnt == 3'd7;
            tx_underrun <= byte_start && !tx_full;
            tx_full     <= tx_load || (tx_full && !byte_start);
            if (tx_load)
                tx_buf <= tx_data;
            if (!running) begin
                bit_cnt  <= 3'd0;
                spi_miso <= 1'b1;
            end else if (sclk_fall) begin
                spi_miso <= byte_start ? tx_next[7] : tx_sh[7];
                tx_sh    <= byte_start ? {tx_next[6:0], 1'b0} : {tx_sh[6:0], 1'b0};
            end else if (sclk_rise) begin
                rx_sh   <= {rx_sh[5:0], mosi_s};
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7)
                    rx_data <= {rx_sh, mosi_s};
            end
        end
    end
endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed and randomized host frames checked against a byte-level buffer model
module tb_spi_responder;
    localparam int         H    = 8;
    localparam logic [7:0] IDLE = 8'hFF;

    logic       clk_48 = 1'b0, rst = 1'b1;
    logic       spi_cs_n = 1'b1, spi_clk = 1'b1, spi_mosi = 1'b0;
    logic       spi_miso, spi_miso_oe, rx_valid, tx_load = 1'b0, tx_empty, tx_underrun;
    logic       frame_active, frame_start, frame_end;
    logic [7:0] rx_data, tx_data = 8'h00;

    spi_responder dut (
        .clk_48(clk_48), .rst(rst), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe), .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_data(tx_data), .tx_load(tx_load), .tx_empty(tx_empty), .tx_underrun(tx_underrun),
        .frame_active(frame_active), .frame_start(frame_start), .frame_end(frame_end)
    );

    always #10 clk_48 = ~clk_48;

    int         checks = 0, errors = 0;
    int         n_fs = 0, n_fe = 0, n_und = 0, n_er = 0;
    logic       empty_d = 1'b1;
    logic [7:0] rxq[$];
    logic [7:0] mo[4], got[4];
    logic [7:0] hook_val = 8'h00, m_buf = 8'h00;
    logic       hook_empty = 1'b1, m_full = 1'b0;
    int         b_fs, b_fe, b_und, b_er, b_rx;

    always @(negedge clk_48) begin
        if (rx_valid) rxq.push_back(rx_data);
        if (frame_start) n_fs++;
        if (frame_end) n_fe++;
        if (tx_underrun) n_und++;
        if (tx_empty && !empty_d) n_er++;
        empty_d = tx_empty;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rx_at(input int i);
        return (rxq.size() > i) ? {24'h0, rxq[i]} : 32'hDEAD;
    endfunction

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk_48);
    endtask

    task automatic snap();
        b_fs = n_fs; b_fe = n_fe; b_und = n_und; b_er = n_er; b_rx = rxq.size();
    endtask

    task automatic cpu_load(input logic [7:0] v);
        tx_data = v; tx_load = 1'b1;
        wait_n(1);
        tx_load = 1'b0; m_full = 1'b1; m_buf = v;
        wait_n(1);
    endtask

    // hook fires tx_load in the very cycle the responder acts on this byte's first falling edge
    task automatic host_byte(input logic [7:0] b, input int nbits, input bit hook, output logic [7:0] r);
        r = 8'h00;
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_clk = 1'b0; spi_mosi = b[i];
            if (hook && i == 7) begin
                wait_n(2);
                tx_data = hook_val; tx_load = 1'b1;
                wait_n(1);
                tx_load = 1'b0; hook_empty = tx_empty;
                wait_n(H - 3);
            end else
                wait_n(H);
            r[i] = spi_miso; spi_clk = 1'b1;
            wait_n(H);
        end
    endtask

    task automatic frame(input int n, input int hook_at);
        spi_cs_n = 1'b0;
        wait_n(H);
        for (int k = 0; k < n; k++) host_byte(mo[k], 8, k == hook_at, got[k]);
        spi_cs_n = 1'b1;
        wait_n(2 * H);
    endtask

    initial begin
        logic [7:0] r;
        wait_n(3);
        chk("rst_miso", spi_miso, 1);
        chk("rst_oe", spi_miso_oe, 0);
        chk("rst_rx_data", rx_data, 8'h00);
        chk("rst_tx_empty", tx_empty, 1);
        chk("rst_active", frame_active, 0);
        chk("rst_strobes", {rx_valid, tx_underrun, frame_start, frame_end}, 0);
        rst = 1'b0;
        wait_n(2 * H);

        // single byte: preloaded 3C out, A5 in
        cpu_load(8'h3C);
        chk("t1_empty_after_load", tx_empty, 0);
        snap();
        spi_cs_n = 1'b0;
        wait_n(1);
        chk("t1_active_early", frame_active, 0);
        wait_n(3);
        chk("t1_active", frame_active, 1);
        chk("t1_oe", spi_miso_oe, 1);
        wait_n(H - 4);
        host_byte(8'hA5, 8, 0, got[0]);
        spi_cs_n = 1'b1;
        wait_n(2 * H);
        m_full = 1'b0;
        chk("t1_miso_byte", got[0], 8'h3C);
        chk("t1_rx_count", rxq.size() - b_rx, 1);
        chk("t1_rx_byte", rx_at(b_rx), 8'hA5);
        chk("t1_frame_start", n_fs - b_fs, 1);
        chk("t1_frame_end", n_fe - b_fe, 1);
        chk("t1_empty_rise", n_er - b_er, 1);
        chk("t1_no_underrun", n_und - b_und, 0);
        chk("t1_idle_miso", spi_miso, 1);
        chk("t1_idle_oe", spi_miso_oe, 0);

        // two bytes with nothing buffered
        snap();
        mo[0] = 8'h12; mo[1] = 8'h34;
        frame(2, -1);
        chk("t2_miso0", got[0], IDLE);
        chk("t2_miso1", got[1], IDLE);
        chk("t2_underrun", n_und - b_und, 2);
        chk("t2_rx_count", rxq.size() - b_rx, 2);
        chk("t2_rx0", rx_at(b_rx), 8'h12);
        chk("t2_rx1", rx_at(b_rx + 1), 8'h34);

        // CPU refills the buffer on each tx_empty rise
        cpu_load(8'h01);
        snap();
        for (int k = 0; k < 4; k++) mo[k] = 8'($urandom);
        fork
            frame(4, -1);
            begin
                for (int k = 2; k <= 4; k++) begin
                    int t;
                    t = 0;
                    while (tx_empty !== 1'b1 && t < 2000) begin
                        wait_n(1);
                        t++;
                    end
                    chk("t3_cpu_wait", t < 2000, 1);
                    tx_data = 8'(k); tx_load = 1'b1;
                    wait_n(1);
                    tx_load = 1'b0;
                    wait_n(1);
                end
            end
        join
        m_full = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t3_miso", got[k], 8'(k + 1));
            chk("t3_rx", rx_at(b_rx + k), {24'h0, mo[k]});
        end
        chk("t3_underrun", n_und - b_und, 0);
        chk("t3_empty_end", tx_empty, 1);

        // randomized frames against the byte-level buffer model
        for (int it = 0; it < 6; it++) begin
            int nl, nb;
            nl = $urandom_range(0, 2);
            nb = $urandom_range(1, 3);
            for (int j = 0; j < nl; j++) cpu_load(8'($urandom));
            for (int k = 0; k < nb; k++) mo[k] = 8'($urandom);
            snap();
            frame(nb, -1);
            for (int k = 0; k < nb; k++) begin
                chk("rnd_miso", got[k], (k == 0 && m_full) ? m_buf : IDLE);
                chk("rnd_rx", rx_at(b_rx + k), {24'h0, mo[k]});
            end
            chk("rnd_rx_count", rxq.size() - b_rx, nb);
            chk("rnd_underrun", n_und - b_und, nb - (m_full ? 1 : 0));
            m_full = 1'b0;
            chk("rnd_empty", tx_empty, 1);
        end

        // CS raised after 5 bits: partial byte dropped, buffered byte consumed
        cpu_load(8'hAB);
        snap();
        spi_cs_n = 1'b0;
        wait_n(H);
        host_byte(8'h5A, 5, 0, r);
        spi_cs_n = 1'b1;
        wait_n(2 * H);
        m_full = 1'b0;
        chk("ab_rx_count", rxq.size() - b_rx, 0);
        chk("ab_frame_end", n_fe - b_fe, 1);
        chk("ab_partial_miso", r[7:3], 5'b10101);
        chk("ab_empty", tx_empty, 1);
        snap();
        mo[0] = 8'hC3;
        frame(1, -1);
        chk("ab_next_rx", rx_at(b_rx), 8'hC3);
        chk("ab_next_miso", got[0], IDLE);
        chk("ab_next_underrun", n_und - b_und, 1);

        // tx_load coinciding with a byte start
        cpu_load(8'h55);
        snap();
        hook_val = 8'h77; mo[0] = 8'h0F; mo[1] = 8'hF0;
        frame(2, 0);
        m_full = 1'b0;
        chk("same_cycle_miso0", got[0], 8'h55);
        chk("same_cycle_miso1", got[1], 8'h77);
        chk("same_cycle_empty", hook_empty, 0);
        chk("same_cycle_underrun", n_und - b_und, 0);
        chk("same_cycle_rx1", rx_at(b_rx + 1), 8'hF0);

        // reset mid-byte with CS held low
        cpu_load(8'h99);
        spi_cs_n = 1'b0;
        wait_n(H);
        host_byte(8'h0F, 4, 0, r);
        spi_clk = 1'b0;
        wait_n(2);
        rst = 1'b1;
        #1;
        chk("mid_rst_miso", spi_miso, 1);
        chk("mid_rst_oe", spi_miso_oe, 0);
        chk("mid_rst_rx_data", rx_data, 8'h00);
        chk("mid_rst_empty", tx_empty, 1);
        chk("mid_rst_active", frame_active, 0);
        wait_n(1);
        rst = 1'b0; m_full = 1'b0;
        wait_n(H);
        snap();
        spi_clk = 1'b1;
        wait_n(H);
        host_byte(8'hAA, 8, 0, r);
        host_byte(8'h55, 8, 0, r);
        chk("mid_rst_ignored_rx", rxq.size() - b_rx, 0);
        chk("mid_rst_no_start", n_fs - b_fs, 0);
        chk("mid_rst_inactive", frame_active, 0);
        spi_cs_n = 1'b1;
        wait_n(2 * H);
        snap();
        mo[0] = 8'h5A;
        frame(1, -1);
        chk("post_rst_rx", rx_at(b_rx), 8'h5A);
        chk("post_rst_miso", got[0], IDLE);
        chk("post_rst_start", n_fs - b_fs, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
